// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types and width helpers for the preemptible context-save stack controller.
package rt_ibex_pcs_pkg;

    localparam int unsigned PcsDefaultDepth = 8;

    typedef enum logic [2:0] {
        PcsIdle,
        PcsSave,
        PcsRdReq,
        PcsRdRsp,
        PcsAck
    } pcs_state_e;

    // Stack pointer must represent 0..Depth inclusive.
    function automatic int unsigned pcs_sp_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned pcs_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rt_ibex_pcs_lvl_stack.sv
// Per-frame interrupt level storage: push at sp, replace/read the top frame at sp-1.
module rt_ibex_pcs_lvl_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter  int unsigned Depth         = PcsDefaultDepth,
    parameter  int unsigned IrqLevelWidth = 8,
    localparam int unsigned SpW           = pcs_sp_width(Depth),
    localparam int unsigned AddrW         = pcs_addr_width(Depth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     replace_i,
    input  logic [SpW-1:0]           sp_i,
    input  logic [IrqLevelWidth-1:0] level_i,
    output logic [IrqLevelWidth-1:0] top_o
);

    logic [IrqLevelWidth-1:0] lvl_q [Depth];
    logic [AddrW-1:0]         push_idx;
    logic [AddrW-1:0]         top_idx;

    assign push_idx = sp_i[AddrW-1:0];
    assign top_idx  = AddrW'(sp_i - SpW'(1));

    // NOTE: this array is small control state that level_o exposes directly, so every
    // entry is reset; the bulk register data lives in the external SRAM and is not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                lvl_q[i] <= '0;
            end
        end else if (push_i) begin
            lvl_q[push_idx] <= level_i;
        end else if (replace_i) begin
            lvl_q[top_idx] <= level_i;
        end
    end

    assign top_o = (sp_i != '0) ? lvl_q[top_idx] : '0;

endmodule

// File: rtl/rt_ibex_pcs_ctrl.sv
// PCS stack controller: turns IRQ entry/return events into push/pop transfers on a
// single-port latency-1 SRAM, tracking nesting depth and per-frame interrupt level.
module rt_ibex_pcs_ctrl
    import rt_ibex_pcs_pkg::*;
#(
    parameter  int unsigned NrSavedRegs   = 9,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned Depth         = PcsDefaultDepth,
    parameter  int unsigned IrqLevelWidth = 8,
    localparam int unsigned SpW           = pcs_sp_width(Depth),
    localparam int unsigned AddrW         = pcs_addr_width(Depth),
    localparam int unsigned MemW          = NrSavedRegs * DataWidth
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   irq_ack_i,
    input  logic [IrqLevelWidth-1:0]               irq_level_i,
    input  logic                                   mret_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]  store_data_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]  restore_data_o,
    output logic                                   restore_en_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [IrqLevelWidth-1:0]               level_o,
    output logic [SpW-1:0]                         depth_o,
    output logic                                   err_o,
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [AddrW-1:0]                       mem_addr_o,
    output logic [MemW-1:0]                        mem_wdata_o,
    input  logic [MemW-1:0]                        mem_rdata_i
);

    pcs_state_e               state_q, state_d;
    logic [SpW-1:0]           sp_q;
    logic                     err_q;
    logic [IrqLevelWidth-1:0] cap_level_q;

    logic sp_full, sp_empty;
    logic sp_inc, sp_dec, err_set, cap_en, lvl_push, lvl_replace;
    logic [IrqLevelWidth-1:0] lvl_wdata;

    assign sp_full  = (sp_q == SpW'(Depth));
    assign sp_empty = (sp_q == '0);

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        sp_inc         = 1'b0;
        sp_dec         = 1'b0;
        err_set        = 1'b0;
        cap_en         = 1'b0;
        lvl_replace    = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        restore_data_o = '0;
        restore_en_o   = 1'b0;
        done_o         = 1'b0;

        unique case (state_q)
            PcsIdle: begin
                if (irq_ack_i && mret_i && !sp_empty) begin
                    // Tail-chain: the new handler reuses the frame being returned from.
                    lvl_replace = 1'b1;
                    state_d     = PcsAck;
                end else if (irq_ack_i) begin
                    err_set = mret_i;
                    if (!sp_full) begin
                        cap_en  = 1'b1;
                        state_d = PcsSave;
                    end else begin
                        err_set = 1'b1;
                        state_d = PcsAck;
                    end
                end else if (mret_i) begin
                    if (!sp_empty) begin
                        state_d = PcsRdReq;
                    end else begin
                        err_set = 1'b1;
                        state_d = PcsAck;
                    end
                end
            end
            PcsSave: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = sp_q[AddrW-1:0];
                for (int unsigned i = 0; i < NrSavedRegs; i++) begin
                    mem_wdata_o[DataWidth*i +: DataWidth] = store_data_i[i];
                end
                sp_inc  = 1'b1;
                done_o  = 1'b1;
                state_d = PcsIdle;
            end
            PcsRdReq: begin
                mem_req_o  = 1'b1;
                mem_addr_o = AddrW'(sp_q - SpW'(1));
                state_d    = PcsRdRsp;
            end
            PcsRdRsp: begin
                for (int unsigned i = 0; i < NrSavedRegs; i++) begin
                    restore_data_o[i] = mem_rdata_i[DataWidth*i +: DataWidth];
                end
                restore_en_o = 1'b1;
                done_o       = 1'b1;
                sp_dec       = 1'b1;
                state_d      = PcsIdle;
            end
            PcsAck: begin
                done_o  = 1'b1;
                state_d = PcsIdle;
            end
            default: state_d = PcsIdle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= PcsIdle;
            sp_q        <= '0;
            err_q       <= 1'b0;
            cap_level_q <= '0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (cap_en) begin
                cap_level_q <= irq_level_i;
            end
            if (sp_inc && !sp_full) begin
                sp_q <= sp_q + SpW'(1);
            end else if (sp_dec && !sp_empty) begin
                sp_q <= sp_q - SpW'(1);
            end
        end
    end

    assign lvl_push  = (state_q == PcsSave);
    assign lvl_wdata = lvl_push ? cap_level_q : irq_level_i;

    rt_ibex_pcs_lvl_stack #(
        .Depth         (Depth),
        .IrqLevelWidth (IrqLevelWidth)
    ) u_lvl_stack (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (lvl_push),
        .replace_i (lvl_replace),
        .sp_i      (sp_q),
        .level_i   (lvl_wdata),
        .top_o     (level_o)
    );

    assign busy_o  = (state_q != PcsIdle);
    assign depth_o = sp_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Directed bench for rt_ibex_pcs_ctrl with a behavioural latency-1 SRAM.
module tb_rt_ibex_pcs_ctrl;

    localparam int unsigned NrSavedRegs   = 9;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned Depth         = 8;
    localparam int unsigned IrqLevelWidth = 8;
    localparam int unsigned SpW           = 4;
    localparam int unsigned AddrW         = 3;
    localparam int unsigned MemW          = NrSavedRegs * DataWidth;

    typedef logic [NrSavedRegs-1:0][DataWidth-1:0] regs_t;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     irq_ack_i = 1'b0;
    logic [IrqLevelWidth-1:0] irq_level_i = '0;
    logic                     mret_i = 1'b0;
    regs_t                    store_data_i = '0;
    regs_t                    restore_data_o;
    logic                     restore_en_o;
    logic                     busy_o;
    logic                     done_o;
    logic [IrqLevelWidth-1:0] level_o;
    logic [SpW-1:0]           depth_o;
    logic                     err_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [AddrW-1:0]         mem_addr_o;
    logic [MemW-1:0]          mem_wdata_o;
    logic [MemW-1:0]          mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    logic [MemW-1:0] sram [Depth];

    rt_ibex_pcs_ctrl #(
        .NrSavedRegs   (NrSavedRegs),
        .DataWidth     (DataWidth),
        .Depth         (Depth),
        .IrqLevelWidth (IrqLevelWidth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .irq_ack_i      (irq_ack_i),
        .irq_level_i    (irq_level_i),
        .mret_i         (mret_i),
        .store_data_i   (store_data_i),
        .restore_data_o (restore_data_o),
        .restore_en_o   (restore_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .level_o        (level_o),
        .depth_o        (depth_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i <= sram[mem_addr_o];
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(busy_o && (irq_ack_i || mret_i)))
                else $error("event issued while busy");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic regs_t exp_data(input logic [31:0] base);
        regs_t r;
        for (int i = 0; i < NrSavedRegs; i++) r[i] = base + 32'(i);
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        irq_ack_i = 1'b0;
        mret_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Push and return at the first idle negedge after the operation.
    task automatic do_push(input logic [7:0] lvl, input logic [31:0] base);
        store_data_i = exp_data(base);
        irq_level_i = lvl;
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL push_done lvl=%0d: got %b expected 1", lvl, done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, restore_en_o, err_o, mem_req_o, mem_we_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {busy_o, done_o, restore_en_o, err_o, mem_req_o, mem_we_o});
        end
        checks++;
        if (level_o !== 8'd0 || depth_o !== 4'd0) begin
            errors++; $display("FAIL reset_level_depth: got %0d/%0d expected 0/0", level_o, depth_o);
        end
        checks++;
        if (mem_addr_o !== 3'd0 || mem_wdata_o !== '0 || restore_data_o !== '0) begin
            errors++; $display("FAIL reset_buses: got addr %0d wdata %h rdata %h expected zeros",
                               mem_addr_o, mem_wdata_o, restore_data_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_save();
        regs_t exp_first;
        exp_first = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        store_data_i = exp_data(32'd1);
        irq_level_i = 8'd3;
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 3'd0) begin
            errors++; $display("FAIL save_cmd: got req %b we %b addr %0d expected 1 1 0", mem_req_o, mem_we_o, mem_addr_o);
        end
        checks++;
        if (mem_wdata_o !== exp_first) begin
            errors++; $display("FAIL save_wdata: got %h expected %h", mem_wdata_o, exp_first);
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || depth_o !== 4'd0) begin
            errors++; $display("FAIL save_cycle1: got done %b busy %b depth %0d expected 1 1 0", done_o, busy_o, depth_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd1 || level_o !== 8'd3 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL save_cycle2: got depth %0d level %0d done %b busy %b expected 1 3 0 0",
                               depth_o, level_o, done_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_addr  [3] = '{3'd2, 3'd1, 3'd0};
        logic [31:0] exp_base  [3] = '{32'h700, 32'h500, 32'd1};
        logic [7:0]  exp_level [3] = '{8'd5, 8'd3, 8'd0};
        do_push(8'd5, 32'h500);
        do_push(8'd7, 32'h700);
        checks++;
        if (depth_o !== 4'd3 || level_o !== 8'd7) begin
            errors++; $display("FAIL push3: got depth %0d level %0d expected 3 7", depth_o, level_o);
        end
        for (int k = 0; k < 3; k++) begin
            mret_i = 1'b1;
            @(negedge clk_i);
            mret_i = 1'b0;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== exp_addr[k] || restore_en_o !== 1'b0) begin
                errors++; $display("FAIL pop%0d_rdreq: got req %b we %b addr %0d ren %b expected 1 0 %0d 0",
                                   k, mem_req_o, mem_we_o, mem_addr_o, restore_en_o, exp_addr[k]);
            end
            @(negedge clk_i);
            checks++;
            if (restore_en_o !== 1'b1 || done_o !== 1'b1 || restore_data_o !== exp_data(exp_base[k])) begin
                errors++; $display("FAIL pop%0d_rsp: got ren %b done %b data %h expected 1 1 %h",
                                   k, restore_en_o, done_o, restore_data_o, exp_data(exp_base[k]));
            end
            @(negedge clk_i);
            checks++;
            if (depth_o !== 4'(2 - k) || level_o !== exp_level[k] || restore_en_o !== 1'b0) begin
                errors++; $display("FAIL pop%0d_after: got depth %0d level %0d ren %b expected %0d %0d 0",
                                   k, depth_o, level_o, restore_en_o, 2 - k, exp_level[k]);
            end
        end
    endtask

    task automatic test_tail_chain();
        do_push(8'd4, 32'h40);
        irq_level_i = 8'd9;
        irq_ack_i = 1'b1;
        mret_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        mret_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++; $display("FAIL tail_cycle1: got req %b done %b busy %b expected 0 1 1", mem_req_o, done_o, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd1 || level_o !== 8'd9 || err_o !== 1'b0) begin
            errors++; $display("FAIL tail_after: got depth %0d level %0d err %b expected 1 9 0", depth_o, level_o, err_o);
        end
        mret_i = 1'b1;
        @(negedge clk_i);
        mret_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd0 || level_o !== 8'd0) begin
            errors++; $display("FAIL tail_pop: got depth %0d level %0d expected 0 0", depth_o, level_o);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 8; k++) do_push(8'(k), 32'(k) * 32'h100);
        checks++;
        if (depth_o !== 4'd8 || level_o !== 8'd8 || err_o !== 1'b0) begin
            errors++; $display("FAIL full: got depth %0d level %0d err %b expected 8 8 0", depth_o, level_o, err_o);
        end
        irq_level_i = 8'd10;
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || done_o !== 1'b1 || err_o !== 1'b1) begin
            errors++; $display("FAIL overflow_cycle1: got req %b done %b err %b expected 0 1 1", mem_req_o, done_o, err_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd8 || level_o !== 8'd8 || busy_o !== 1'b0) begin
            errors++; $display("FAIL overflow_after: got depth %0d level %0d busy %b expected 8 8 0", depth_o, level_o, busy_o);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        mret_i = 1'b1;
        @(negedge clk_i);
        mret_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || restore_en_o !== 1'b0 || mem_req_o !== 1'b0 || err_o !== 1'b1) begin
            errors++; $display("FAIL underflow_cycle1: got done %b ren %b req %b err %b expected 1 0 0 1",
                               done_o, restore_en_o, mem_req_o, err_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd0 || restore_en_o !== 1'b0 || err_o !== 1'b1) begin
            errors++; $display("FAIL underflow_after: got depth %0d ren %b err %b expected 0 0 1", depth_o, restore_en_o, err_o);
        end
    endtask

    task automatic test_both_empty();
        apply_reset();
        store_data_i = exp_data(32'h600);
        irq_level_i = 8'd6;
        irq_ack_i = 1'b1;
        mret_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        mret_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 3'd0 || err_o !== 1'b1) begin
            errors++; $display("FAIL both_empty_cycle1: got req %b we %b addr %0d err %b expected 1 1 0 1",
                               mem_req_o, mem_we_o, mem_addr_o, err_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd1 || level_o !== 8'd6) begin
            errors++; $display("FAIL both_empty_after: got depth %0d level %0d expected 1 6", depth_o, level_o);
        end
    endtask

    task automatic test_reset_midop();
        mret_i = 1'b1;
        @(negedge clk_i);
        mret_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 3'd0) begin
            errors++; $display("FAIL midop_rdreq: got req %b we %b addr %0d expected 1 0 0", mem_req_o, mem_we_o, mem_addr_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || depth_o !== 4'd0) begin
            errors++; $display("FAIL midop_reset: got req %b busy %b depth %0d expected 0 0 0", mem_req_o, busy_o, depth_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        store_data_i = exp_data(32'h200);
        irq_level_i = 8'd2;
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 3'd0) begin
            errors++; $display("FAIL midop_repush: got req %b we %b addr %0d expected 1 1 0", mem_req_o, mem_we_o, mem_addr_o);
        end
        @(negedge clk_i);
        checks++;
        if (depth_o !== 4'd1 || level_o !== 8'd2 || err_o !== 1'b0) begin
            errors++; $display("FAIL midop_after: got depth %0d level %0d err %b expected 1 2 0", depth_o, level_o, err_o);
        end
    endtask

    initial begin
        test_reset();
        test_save();
        test_back_to_back();
        test_tail_chain();
        test_overflow();
        test_underflow();
        test_both_empty();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rt_ibex_pcs_ctrl.md
# rt_ibex_pcs_ctrl

Stack controller for the preemptible context-save (PCS) memory. It converts core interrupt-entry (`irq_ack_i`) and interrupt-return (`mret_i`) events into push and pop operations on a single-port, latency-1 SRAM holding saved register banks. It tracks nesting depth and the active interrupt level per nesting frame, and handles tail-chaining, overflow and underflow. It sits between the core's IRQ/CSR logic and a `tc_sram` instance that is placed one level up.

## Interface
- `NrSavedRegs`, default 9: registers per saved context.
- `DataWidth`, default 32: register width.
- `Depth`, default 8: max nesting frames; must be ≥2.
- `IrqLevelWidth`, default 8: interrupt level width.
- Derived widths: `SpW` = $clog2(Depth+1); `AddrW` = $clog2(Depth); `MemW` = NrSavedRegs*DataWidth.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `irq_ack_i` in 1: interrupt taken; push context.
- `irq_level_i` in IrqLevelWidth: level of the acked interrupt.
- `mret_i` in 1: return pending; pop context.
- `store_data_i` in [NrSavedRegs][DataWidth]: live registers to save.
- `restore_data_o` out [NrSavedRegs][DataWidth]: restored registers.
- `restore_en_o` out 1: write `restore_data_o` into the register file this cycle.
- `busy_o` out 1: operation in flight; the core holds `store_data_i` and issues no events.
- `done_o` out 1: one-cycle pulse in the last cycle of any operation.
- `level_o` out IrqLevelWidth: level of the top frame; 0 when empty.
- `depth_o` out SpW: current stack pointer (`sp`).
- `err_o` out 1: sticky error (overflow or underflow); cleared only by reset.
- `mem_req_o`, `mem_we_o` out 1: SRAM request and write enable.
- `mem_addr_o` out AddrW: SRAM address.
- `mem_wdata_o` out MemW: SRAM write data.
- `mem_rdata_i` in MemW: SRAM read data, valid one cycle after a read request.

## Operation
- Packing: register i maps to bits [DataWidth*i +: DataWidth] in both directions.
- FSM states: IDLE, SAVE, RD_REQ, RD_RSP, ACK.
- IDLE, events sampled in priority order:
  - `irq_ack_i` and `mret_i` together, with `sp`>0 (tail-chain): go to ACK. No memory access; the top frame level is replaced by `irq_level_i`; `sp` is unchanged.
  - `irq_ack_i` and `mret_i` together, with `sp`==0: handled as a plain `irq_ack_i`, and `err_o` is set.
  - `irq_ack_i` with `sp`<Depth: capture `irq_level_i` and go to SAVE.
  - `irq_ack_i` with `sp`==Depth (full): set `err_o` and go to ACK. No write.
  - `mret_i` with `sp`>0: go to RD_REQ.
  - `mret_i` with `sp`==0 (empty): set `err_o` and go to ACK. `restore_en_o` stays low.
- SAVE:
  - Drive `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`=`sp`, `mem_wdata_o`=packed `store_data_i`.
  - Write the captured level to `lvl[sp]`; increment `sp`; assert `done_o`; go to IDLE.
- RD_REQ: drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=`sp`-1; go to RD_RSP.
- RD_RSP:
  - `restore_data_o` = unpacked `mem_rdata_i`; `restore_en_o`=1; `done_o`=1.
  - Decrement `sp`; go to IDLE.
- ACK: `done_o`=1; go to IDLE.
- Events asserted while `busy_o`=1 are ignored; a bench assertion flags them.
- `level_o` = `lvl[sp-1]` when `sp`>0, else 0.
- `busy_o` = (state != IDLE), combinational.

## Timing
- All outputs reset to 0: `busy_o`, `done_o`, `restore_en_o`, `err_o`, `level_o`, `depth_o`, all `mem_*_o`, `restore_data_o`. State resets to IDLE, `sp` to 0, the level stack to 0.
- Event sampled in cycle 0 (IDLE). Operations then complete as follows:
  - Save: SAVE in cycle 1; `depth_o` increments in cycle 2.
  - Restore: RD_REQ in cycle 1; RD_RSP and `restore_en_o` in cycle 2; `depth_o` decrements in cycle 3.
  - Tail-chain or error: ACK in cycle 1.
- Back-to-back: a new event is accepted in the first IDLE cycle after `done_o`.
- `mem_*_o`, `restore_en_o` and `done_o` are combinational from state; no output depends combinationally on an `*_i` event.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously and `mem_req_o` drops immediately. SRAM contents are don't-care after reset.
- `sp` never wraps: it saturates at Depth and at 0, and the error paths cover both limits.

## Structure
- Package `rt_ibex_pcs_pkg` holds:
  - `pcs_state_e` (the five states);
  - the width helper functions;
  - the `PcsDefaultDepth` constant.
- Sub-module `rt_ibex_pcs_lvl_stack`: a Depth × IrqLevelWidth flop array with push, pop-free read and top-replace ports, all indexed by `sp`.
- The SRAM is not instantiated inside this block.

## Test plan
- Reset, then `irq_ack_i` with level 3 and `store_data_i[i]`=i+1:
  - SAVE write to addr 0 with packed data;
  - `depth_o` becomes 1; `level_o` becomes 3;
  - `done_o` pulses in cycle 1.
- Push levels 3, 5, 7, then three `mret_i`:
  - reads at addrs 2, 1, 0;
  - `restore_en_o` in cycle 2 of each pop, with matching data;
  - `level_o` sequence 5, 3, 0.
- At `depth_o`=1, `irq_ack_i`+`mret_i` together with level 9:
  - no `mem_req_o`; `depth_o` stays 1; `level_o` becomes 9;
  - `done_o` in cycle 1; `err_o`=0.
- Depth+1 pushes:
  - the final push produces no write, `err_o`=1 and `done_o`;
  - `depth_o` holds at 8.
- `mret_i` when empty:
  - `err_o`=1; `restore_en_o` stays 0; `depth_o`=0.
- Assert `rst_ni` low during RD_REQ:
  - `mem_req_o`, `busy_o` and `depth_o` go to 0 immediately;
  - after release, a fresh push writes addr 0.
